// File: rtl/activation_arbiter.sv
// activation_arbiter: round-robin front end that shares one registered
// activation unit among NUM_REQ requesters. Accepted operands travel through
// two tagged in-flight stages (operand register, unit result register) and
// are then queued in a response FIFO in accept order. Issue is credit-limited
// so the FIFO can never overflow.
// Optional feature: define ACT_ARB_PERF_EN to add per-requester 16-bit
// saturating accept counters on output grant_count.
module activation_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [16*NUM_REQ-1:0]      req_data,
  input  logic [2*NUM_REQ-1:0]       req_func,
  output logic [15:0]                act_data_in,
  output logic [1:0]                 act_func_select,
  input  logic [15:0]                act_data_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [15:0]                rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id
`ifdef ACT_ARB_PERF_EN
  ,
  output logic [16*NUM_REQ-1:0]      grant_count
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] winner;
  logic           found;
  logic           credit_ok;
  logic           accept;
  logic [15:0]    sel_data;
  logic [1:0]     sel_func;

  logic           s1_valid;
  logic [IDW-1:0] s1_id;
  logic           s2_valid;
  logic [IDW-1:0] s2_id;

  logic [16+IDW-1:0] fifo_mem [RSP_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;
  logic              push;
  logic              pop;

  // Round-robin search: first valid requester strictly after last_grant.
  always_comb begin
    int unsigned    cand;
    logic [IDW-1:0] cand_id;
    winner  = '0;
    found   = 1'b0;
    cand    = 0;
    cand_id = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand    = (32'(last_grant) + k) % unsigned'(NUM_REQ);
      cand_id = IDW'(cand);
      if (!found && req_valid[cand_id]) begin
        found  = 1'b1;
        winner = cand_id;
      end
    end
  end

  // Credit check (a same-cycle pop is not counted) and one-hot ready.
  always_comb begin
    int unsigned occ;
    occ       = 32'(s1_valid) + 32'(s2_valid) + 32'(fifo_count);
    credit_ok = occ < unsigned'(RSP_DEPTH);
    accept    = found && credit_ok;
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  // Operand/function mux for the current winner.
  always_comb begin
    sel_data = '0;
    sel_func = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_data = req_data[16*i +: 16];
        sel_func = req_func[2*i +: 2];
      end
    end
  end

  // Issue register, arbitration pointer and the two tagged in-flight stages.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      act_data_in     <= '0;
      act_func_select <= '0;
      last_grant      <= IDW'(NUM_REQ - 1);
      s1_valid        <= 1'b0;
      s1_id           <= '0;
      s2_valid        <= 1'b0;
      s2_id           <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (accept) begin
        act_data_in     <= sel_data;
        act_func_select <= sel_func;
        s1_id           <= winner;
        last_grant      <= winner;
      end
    end
  end

  assign push = s2_valid;
  assign pop  = rsp_valid && rsp_ready;

  // Response FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Response storage; contents are only observed while the FIFO is non-empty.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {s2_id, act_data_out};
  end

  // Head presentation, forced to zero when empty so reset shows zeros.
  always_comb begin
    rsp_valid = (fifo_count != '0);
    rsp_data  = '0;
    rsp_id    = '0;
    if (rsp_valid) begin
      rsp_data = fifo_mem[rd_ptr][15:0];
      rsp_id   = fifo_mem[rd_ptr][16 +: IDW];
    end
  end

`ifdef ACT_ARB_PERF_EN
  // Per-requester saturating accept counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept && winner == IDW'(i) && grant_count[16*i +: 16] != 16'hFFFF)
          grant_count[16*i +: 16] <= grant_count[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_activation_arbiter.sv
// Self-checking bench for activation_arbiter: models the shared activation
// unit, scoreboards every accepted request and checks the round-robin order.
module tb_activation_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int RSP_DEPTH = 4;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [16*NUM_REQ-1:0] req_data;
  logic [2*NUM_REQ-1:0]  req_func;
  logic [15:0]           act_data_in;
  logic [1:0]            act_func_select;
  logic [15:0]           act_data_out;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_data;
  logic [1:0]            rsp_id;
`ifdef ACT_ARB_PERF_EN
  logic [16*NUM_REQ-1:0] grant_count;
`endif

  activation_arbiter #(.NUM_REQ(NUM_REQ), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_func(req_func),
    .act_data_in(act_data_in), .act_func_select(act_func_select),
    .act_data_out(act_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id)
`ifdef ACT_ARB_PERF_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 clock = ~clock;

  // Piecewise-linear Q8.8 activation unit.
  function automatic logic [15:0] unit_f(input logic [15:0] x, input logic [1:0] f);
    int v;
    int t;
    v = int'($signed(x));
    case (f)
      2'b00: t = v;
      2'b01: t = (v < 0) ? 0 : v;
      2'b10: begin
        t = 128 + (v >>> 2);
        if (t < 0) t = 0;
        if (t > 256) t = 256;
      end
      default: begin
        t = v - (v >>> 2);
        if (t < -256) t = -256;
        if (t > 256) t = 256;
      end
    endcase
    return 16'(t);
  endfunction

  // Shared unit: one register stage behind its inputs.
  always @(posedge clock) act_data_out <= unit_f(act_data_in, act_func_select);

  typedef struct {
    logic [15:0] data;
    logic [1:0]  id;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int m_last = NUM_REQ - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Arbitration and response monitor; handshakes seen here complete on the next rising edge.
  always @(negedge clock) begin : mon
    int   w;
    exp_t e;
    if (reset_n === 1'b1) begin
      if (req_ready != '0) begin
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++)
          if (w < 0 && req_valid[(m_last + k) % NUM_REQ]) w = (m_last + k) % NUM_REQ;
        check("grant", 32'(req_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) begin
          e.data = unit_f(req_data[16*w +: 16], req_func[2*w +: 2]);
          e.id   = 2'(w);
          sb.push_back(e);
          m_last = w;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [15:0] d, input logic [1:0] f);
    req_data[16*i +: 16] = d;
    req_func[2*i +: 2]   = f;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || rsp_valid) && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_done", 32'(sb.size() == 0 && !rsp_valid), 32'd1);
    rsp_ready = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_act_data"}, 32'(act_data_in), 32'd0);
    check({tag, "_act_func"}, 32'(act_func_select), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
  endtask

  initial begin
    int cnt;
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_func  = '0;
    rsp_ready = 1'b0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Single request from requester 2, ReLU of 1.5.
    @(posedge clock); #1;
    set_req(2, 16'h0180, 2'b01);
    req_valid = 4'b0100;
    @(negedge clock);
    check("single_ready", 32'(req_ready), 32'h4);
    @(posedge clock); #1;
    req_valid = '0;
    check("single_act_data", 32'(act_data_in), 32'h0180);
    check("single_act_func", 32'(act_func_select), 32'h1);
    check("single_lat0", 32'(rsp_valid), 32'd0);
    @(posedge clock); #1;
    check("single_lat1", 32'(rsp_valid), 32'd0);
    @(posedge clock); #1;
    check("single_lat2", 32'(rsp_valid), 32'd1);
    check("single_data", 32'(rsp_data), 32'h0180);
    check("single_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    check("single_popped", 32'(rsp_valid), 32'd0);

    // All four requesters streaming with the consumer always ready.
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        set_req(i, 16'(k * 64 + i * 16 - 200), 2'((i + k) % 4));
      @(negedge clock);
      check("rr_seq", 32'(req_ready), 32'd1 << ((3 + k) % 4));
      @(posedge clock); #1;
    end
    req_valid = '0;
    drain(20);

    // Tanh of -1.0 from requester 1.
    set_req(1, 16'hFF00, 2'b11);
    req_valid = 4'b0010;
    @(posedge clock); #1;
    req_valid = '0;
    repeat (2) @(posedge clock);
    #1;
    check("tanh_valid", 32'(rsp_valid), 32'd1);
    check("tanh_data", 32'(rsp_data), 32'hFF40);
    check("tanh_id", 32'(rsp_id), 32'd1);
    drain(10);

    // Credit limit: consumer stalled, requester 0 streaming.
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      set_req(0, 16'(300 - k * 100), 2'b01);
      @(negedge clock);
      if (req_ready[0]) cnt++;
      @(posedge clock); #1;
    end
    check("credit_accepts", 32'(cnt), 32'(RSP_DEPTH));
    @(negedge clock);
    check("credit_stall", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    cnt = 0;
    rsp_ready = 1'b1;
    @(negedge clock);
    if (req_ready[0]) cnt++;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_req(0, 16'(k * 8 + 1), 2'b00);
      @(negedge clock);
      if (req_ready[0]) cnt++;
      @(posedge clock); #1;
    end
    check("credit_after_pop", 32'(cnt), 32'd1);
    req_valid = '0;
    drain(30);

    // Reset with two in flight and two queued.
    rsp_ready = 1'b0;
    set_req(0, 16'h0123, 2'b00);
    req_valid = 4'b0001;
    repeat (4) @(posedge clock);
    #1;
    req_valid = '0;
    check("pre_reset_queued", 32'(rsp_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    sb.delete();
    m_last = NUM_REQ - 1;
    @(negedge clock);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'(i * 256 + 5), 2'b00);
    req_valid = 4'hF;
    @(negedge clock);
    check("first_grant_after_reset", 32'(req_ready), 32'h1);
    @(posedge clock); #1;
    req_valid = '0;
    drain(10);

`ifdef ACT_ARB_PERF_EN
    // Saturation of requester 3's accept counter.
    reset_n = 1'b0;
    sb.delete();
    m_last = NUM_REQ - 1;
    @(negedge clock);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    set_req(3, 16'h0042, 2'b00);
    req_valid = 4'b1000;
    repeat (70000) @(posedge clock);
    #1;
    req_valid = '0;
    drain(20);
    check("perf_sat", 32'(grant_count[63:48]), 32'hFFFF);
    check("perf_others", 32'(grant_count[47:0] == 48'd0), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/activation_arbiter.md
ACTIVATION_ARBITER -- requirements
Module: activation_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter RSP_DEPTH, default 4, response FIFO depth (power of two, >=3).
REQ-003 SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid  in  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
REQ-007 SHALL have port req_data  in  16*NUM_REQ  signed Q8.8 operand; requester i in bits [16i+15:16i].
REQ-008 SHALL have port req_func  in  2*NUM_REQ  function code: 00 linear, 01 ReLU, 10 sigmoid, 11 tanh.
REQ-009 SHALL have port act_data_in  out  16  registered operand to the shared activation unit.
REQ-010 SHALL have port act_func_select  out  2  registered function code to the shared activation unit.
REQ-011 SHALL have port act_data_out  in  16  activation unit result, one register stage behind its inputs.
REQ-012 SHALL have port rsp_valid  out  1  response FIFO non-empty.
REQ-013 SHALL have port rsp_ready  in  1  consumer accepts head response.
REQ-014 SHALL have port rsp_data  out  16  head result.
REQ-015 SHALL have port rsp_id  out  $clog2(NUM_REQ)  requester index of head result.

Function
REQ-016 SHALL accept on a clock edge where req_valid[i] & req_ready[i]; the transfer moves req_data/req_func of i into act_data_in/act_func_select.
REQ-017 SHALL assert req_ready only for the round-robin winner and only when (in-flight count + FIFO count) < RSP_DEPTH; req_ready may depend combinationally on req_valid.
REQ-018 SHALL pick the winner as the first valid requester strictly after last_grant, wrapping NUM_REQ-1 -> 0.
REQ-019 SHALL update last_grant only on accept; unchanged when no transfer.
REQ-020 SHALL track two in-flight stages: S1 (operand in act_* regs, tag id), S2 (unit result registering, tag id), each with a valid bit.
REQ-021 SHALL push {act_data_out, S2 id} into the FIFO on the edge where S2 is valid; latency accept edge T -> rsp_valid high after edge T+2 when FIFO was empty.
REQ-022 SHALL sustain one accept per cycle with rsp_ready held high.
REQ-023 SHALL present FIFO head combinationally on rsp_data/rsp_id; pop on rsp_valid & rsp_ready.
REQ-024 SHALL handle simultaneous push and pop in one cycle with count unchanged; push into full FIFO is impossible by REQ-017 credit rule.
REQ-025 SHALL hold act_data_in/act_func_select at last issued values when idle.
REQ-026 SHALL deliver responses in accept order regardless of requester.

Reset
REQ-027 SHALL on reset_n low, immediately: req_ready=0, act_data_in=0, act_func_select=00, S1/S2 valid=0, FIFO empty, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=NUM_REQ-1.
REQ-028 SHALL discard in-flight work on reset mid-operation; no response emitted for transfers accepted before reset.
REQ-029 SHALL have the requester 0 win first arbitration after reset release.

Configuration
REQ-030 SHALL, with ACT_ARB_PERF_EN defined, add output grant_count (16*NUM_REQ): per-requester 16-bit saturating accept counters, reset to 0, holding at 0xFFFF.
REQ-031 SHALL, without ACT_ARB_PERF_EN, omit grant_count and all counter logic; other behaviour identical.

Verification
REQ-032 SHALL cover: single request req 2, data 0x0180, func 01 -> rsp_valid two cycles later, rsp_data 0x0180, rsp_id 2.
REQ-033 SHALL cover: all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle, responses in same order.
REQ-034 SHALL cover: rsp_ready=0, req 0 streaming -> exactly RSP_DEPTH accepts, then req_ready stays 0; one pop -> one more accept.
REQ-035 SHALL cover: req 1 data 0xFF00, func 11 -> rsp_data is the shared unit's tanh output for -1.0, rsp_id 1.
REQ-036 SHALL cover: reset_n pulsed low with 2 in flight and 2 in FIFO -> outputs zero at once, no stale responses after release, first grant to requester 0.
REQ-037 SHALL cover (ACT_ARB_PERF_EN): 70000 accepts from requester 3 -> grant_count[3] = 0xFFFF, others 0.
